queue_param: RTL and testbench

- Parametrised circular-buffer FIFO; the next generation of the 8x8 shift-register queue.
- Executes exactly one enqueue and/or one dequeue per rising edge of the request levels.
- Supports simultaneous enqueue+dequeue, a flush, and full/empty status.
- Has sticky overflow/underflow flags and reports the operation it performed.
- Sits between the slow-domain producer/consumer logic on clock_10KHZ.

---
 rtl/queue_pkg.sv | 15 +
 rtl/req_edge_detect.sv | 28 ++
 rtl/queue_param.sv | 166 ++++++++++++++++
 tb/tb_queue_param.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// Shared types and default sizing for the parametrised circular-buffer queue.
package queue_pkg;

  // Operation committed on the most recent clock edge.
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ENQ  = 2'd1,
    OP_DEQ  = 2'd2,
    OP_BOTH = 2'd3
  } op_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 8;

endpackage : queue_pkg

// File: rtl/req_edge_detect.sv
// Single-bit rising-edge detector.
// ev_out is high while req_in is high and was low on the previous sampled edge.
module req_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic req_in,
  output logic ev_out
);

  logic prev_q;
  logic prev_d;

  // The history simply follows the request level every cycle.
  always_comb begin
    prev_d = req_in;
  end

  // History register, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so that every flop samples pre-edge values,
    // independent of the order in which the always blocks are evaluated.
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign ev_out = req_in & ~prev_q;

endmodule : req_edge_detect

// File: rtl/queue_param.sv
// Parametrised circular-buffer FIFO driven by request-level edges.
// One enqueue and/or one dequeue is committed per rising edge of the request
// levels; flush clears the contents; overflow/underflow flags are sticky.
module queue_param
  import queue_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = DEF_DEPTH,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clock_10KHZ,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  enqueue_in,
  input  logic                  dequeue_in,
  input  logic                  flush_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic [CNT_W-1:0]      len_out,
  output logic                  full_out,
  output logic                  empty_out,
  output logic                  overflow_out,
  output logic                  underflow_out,
  output logic [1:0]            op_out
);

  localparam int PTR_W = $clog2(DEPTH);

  logic enq_ev;
  logic deq_ev;

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      len_q,  len_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  op_t                   op_q,  op_d;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic is_full;
  logic is_empty;

  req_edge_detect u_enq_edge (
    .clk    (clock_10KHZ),
    .rst    (reset),
    .req_in (enqueue_in),
    .ev_out (enq_ev)
  );

  req_edge_detect u_deq_edge (
    .clk    (clock_10KHZ),
    .rst    (reset),
    .req_in (dequeue_in),
    .ev_out (deq_ev)
  );

  assign is_full  = (len_q == CNT_W'(DEPTH));
  assign is_empty = (len_q == '0);

  // Resolve this cycle's events against the current occupancy.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    head_d  = head_q;
    tail_d  = tail_q;
    len_d   = len_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    op_d    = OP_NONE;
    wr_en   = 1'b0;

    if (flush_in) begin
      // Events arriving with a flush are dropped and never raise error flags.
      head_d = '0;
      tail_d = '0;
      len_d  = '0;
    end else begin
      unique case ({enq_ev, deq_ev})
        2'b10: begin
          if (!is_full) begin
            wr_en  = 1'b1;
            tail_d = tail_q + 1'b1;
            len_d  = len_q + CNT_W'(1);
            op_d   = OP_ENQ;
          end else begin
            ovf_d = 1'b1;
          end
        end
        2'b01: begin
          if (!is_empty) begin
            data_d  = mem_q[head_q];
            valid_d = 1'b1;
            head_d  = head_q + 1'b1;
            len_d   = len_q - CNT_W'(1);
            op_d    = OP_DEQ;
          end else begin
            udf_d = 1'b1;
          end
        end
        2'b11: begin
          // The write always lands: when full, the read frees the slot it uses.
          wr_en  = 1'b1;
          tail_d = tail_q + 1'b1;
          if (!is_empty) begin
            data_d  = mem_q[head_q];
            valid_d = 1'b1;
            head_d  = head_q + 1'b1;
            op_d    = OP_BOTH;
          end else begin
            // No bypass: the word just written is not visible to this read.
            len_d = len_q + CNT_W'(1);
            udf_d = 1'b1;
            op_d  = OP_ENQ;
          end
        end
        default: ;
      endcase
    end
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clock_10KHZ) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      op_q    <= OP_NONE;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      len_q   <= len_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      op_q    <= op_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clock_10KHZ) begin
    // NOTE: the storage has no reset; occupancy tracking guarantees that no
    // entry is read before it has been written.
    if (wr_en && !reset) mem_q[tail_q] <= data_in;
  end

  assign data_out       = data_q;
  assign data_valid_out = valid_q;
  assign len_out        = len_q;
  assign full_out       = (len_q == CNT_W'(DEPTH));
  assign empty_out      = (len_q == '0);
  assign overflow_out   = ovf_q;
  assign underflow_out  = udf_q;
  assign op_out         = op_q;

endmodule : queue_param

// File: tb/tb_queue_param.sv
// Directed bench for queue_param with a data scoreboard.
`timescale 1us/1ns
module tb_queue_param;
  import queue_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          enqueue_in;
  logic          dequeue_in;
  logic          flush_in;
  logic [DW-1:0] data_out;
  logic          data_valid_out;
  logic [CW-1:0] len_out;
  logic          full_out;
  logic          empty_out;
  logic          overflow_out;
  logic          underflow_out;
  logic [1:0]    op_out;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] sb[$];

  always #50 clk = ~clk;

  queue_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock_10KHZ    (clk),
    .reset          (reset),
    .data_in        (data_in),
    .enqueue_in     (enqueue_in),
    .dequeue_in     (dequeue_in),
    .flush_in       (flush_in),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .len_out        (len_out),
    .full_out       (full_out),
    .empty_out      (empty_out),
    .overflow_out   (overflow_out),
    .underflow_out  (underflow_out),
    .op_out         (op_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the dequeued word against the oldest scoreboard entry.
  task automatic sb_compare(input string tag);
    logic [DW-1:0] exp;
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      check({tag, "_data"}, 32'(data_out), 32'(exp));
    end
  endtask

  // Pulse enqueue for one cycle; accept-prediction comes from the scoreboard depth.
  task automatic do_enq(input logic [DW-1:0] d, input string tag);
    bit accept;
    accept     = (sb.size() < DEPTH);
    data_in    = d;
    enqueue_in = 1'b1;
    if (accept) sb.push_back(d);
    tick();
    check({tag, "_op"}, 32'(op_out), accept ? 32'(OP_ENQ) : 32'(OP_NONE));
    check({tag, "_len"}, 32'(len_out), 32'(sb.size()));
    enqueue_in = 1'b0;
    tick();
  endtask

  // Pulse dequeue for one cycle and compare data against the scoreboard.
  task automatic do_deq(input string tag);
    bit expect_valid;
    expect_valid = (sb.size() != 0);
    dequeue_in   = 1'b1;
    tick();
    check({tag, "_valid"}, 32'(data_valid_out), 32'(expect_valid));
    if (data_valid_out) sb_compare(tag);
    check({tag, "_len"}, 32'(len_out), 32'(sb.size()));
    dequeue_in = 1'b0;
    tick();
    check({tag, "_pulse_end"}, 32'(data_valid_out), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    reset      = 1'b1;
    data_in    = '0;
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
    flush_in   = 1'b0;
    do_reset();

    // Reset state.
    check("rst_len",   32'(len_out),        32'd0);
    check("rst_empty", 32'(empty_out),      32'd1);
    check("rst_full",  32'(full_out),       32'd0);
    check("rst_data",  32'(data_out),       32'd0);
    check("rst_valid", 32'(data_valid_out), 32'd0);
    check("rst_ovf",   32'(overflow_out),   32'd0);
    check("rst_udf",   32'(underflow_out),  32'd0);
    check("rst_op",    32'(op_out),         32'(OP_NONE));

    // 1: basic ordering.
    do_enq(8'h11, "t1_enq0");
    do_enq(8'h22, "t1_enq1");
    do_enq(8'h33, "t1_enq2");
    check("t1_len3", 32'(len_out), 32'd3);
    for (int i = 0; i < 3; i++) do_deq("t1_deq");
    check("t1_len0",  32'(len_out),   32'd0);
    check("t1_empty", 32'(empty_out), 32'd1);

    // 2: fill to full, overflow, drain across the wrap point.
    for (int i = 1; i <= 8; i++) do_enq(8'(i), "t2_enq");
    check("t2_full",     32'(full_out),     32'd1);
    check("t2_len8",     32'(len_out),      32'd8);
    check("t2_ovf_pre",  32'(overflow_out), 32'd0);
    do_enq(8'h09, "t2_enq9");
    check("t2_ovf",      32'(overflow_out), 32'd1);
    check("t2_len_ovf",  32'(len_out),      32'd8);
    for (int i = 0; i < 8; i++) do_deq("t2_deq");
    check("t2_empty",    32'(empty_out),    32'd1);

    // 3: a held level produces exactly one event.
    data_in    = 8'h77;
    enqueue_in = 1'b1;
    sb.push_back(8'h77);
    tick();
    check("t3_op_first", 32'(op_out), 32'(OP_ENQ));
    for (int i = 1; i < 5; i++) begin
      tick();
      check("t3_op_held", 32'(op_out), 32'(OP_NONE));
    end
    check("t3_len", 32'(len_out), 32'd1);
    enqueue_in = 1'b0;
    tick();
    do_deq("t3_deq");

    // 4: simultaneous enqueue+dequeue while full.
    do_reset();
    for (int i = 0; i < 8; i++) do_enq(8'hA0 + 8'(i), "t4_fill");
    check("t4_full", 32'(full_out), 32'd1);
    data_in    = 8'hB0;
    enqueue_in = 1'b1;
    dequeue_in = 1'b1;
    sb.push_back(8'hB0);
    tick();
    check("t4_valid", 32'(data_valid_out), 32'd1);
    check("t4_data_a0", 32'(data_out), 32'hA0);
    sb_compare("t4_both");
    check("t4_len", 32'(len_out),      32'd8);
    check("t4_op",  32'(op_out),       32'(OP_BOTH));
    check("t4_ovf", 32'(overflow_out), 32'd0);
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) do_deq("t4_drain");
    check("t4_last_b0", 32'(data_out), 32'hB0);

    // 5: simultaneous enqueue+dequeue while empty.
    data_in    = 8'h5C;
    enqueue_in = 1'b1;
    dequeue_in = 1'b1;
    sb.push_back(8'h5C);
    tick();
    check("t5_len",   32'(len_out),        32'd1);
    check("t5_udf",   32'(underflow_out),  32'd1);
    check("t5_op",    32'(op_out),         32'(OP_ENQ));
    check("t5_valid", 32'(data_valid_out), 32'd0);
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
    tick();
    do_deq("t5_deq");
    check("t5_data_5c", 32'(data_out), 32'h5C);

    // 6: flush discards contents and a coincident event, then reset clears flags.
    do_enq(8'hC1, "t6_enq");
    do_enq(8'hC2, "t6_enq");
    do_enq(8'hC3, "t6_enq");
    data_in    = 8'hC4;
    enqueue_in = 1'b1;
    flush_in   = 1'b1;
    tick();
    sb.delete();
    check("t6_len",   32'(len_out),   32'd0);
    check("t6_empty", 32'(empty_out), 32'd1);
    check("t6_op",    32'(op_out),    32'(OP_NONE));
    check("t6_ovf",   32'(overflow_out), 32'd0);
    enqueue_in = 1'b0;
    flush_in   = 1'b0;
    tick();
    do_deq("t6_deq_empty");
    check("t6_data_kept", 32'(data_out), 32'h5C);
    do_reset();
    check("t6_rst_udf",  32'(underflow_out), 32'd0);
    check("t6_rst_ovf",  32'(overflow_out),  32'd0);
    check("t6_rst_data", 32'(data_out),      32'd0);
    check("t6_rst_len",  32'(len_out),       32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_queue_param
